// File: rtl/nt_node_trigger_monitor.sv
// nt_node_trigger_monitor
//   Rare-node trigger monitor. WIDTH channel pairs are each delayed by a
//   per-lane pipeline. The a path has DEPTH stages and the b path has one
//   stage. Each lane then forms term = a_d & ~b_d. All terms are reduced
//   (OR or AND, set by MODE) into a registered node value. The monitor counts
//   the cycles in which that node is active, saturating at the counter limit,
//   and raises a sticky fire flag once the count reaches THRESH.
// Ports:
//   I1470_clk  clock, rising edge
//   I1477_rst  asynchronous active-low reset
//   a_in/b_in  WIDTH-bit channel data
//   en         counting enable
//   clr        synchronous clear of count and fire
//   node_out   registered node value
//   count      saturating event count (CNT_W bits)
//   fire       sticky trigger flag

// Per-lane delay: DEPTH-stage a path, 1-stage b path, and the lane term.
module nt_lane #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  output logic term
);
  logic [DEPTH-1:0] a_pipe;
  logic             b_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_pipe <= '0;
      b_d    <= 1'b0;
    end else begin
      a_pipe[0] <= a;
      for (int s = 1; s < DEPTH; s++) a_pipe[s] <= a_pipe[s-1];
      b_d <= b;
    end
  end

  assign term = a_pipe[DEPTH-1] & ~b_d;
endmodule

module nt_node_trigger_monitor #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 2,
  parameter int MODE   = 0,
  parameter int CNT_W  = 8,
  parameter int THRESH = 16
) (
  input  logic             I1470_clk,
  input  logic             I1477_rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             en,
  input  logic             clr,
  output logic             node_out,
  output logic [CNT_W-1:0] count,
  output logic             fire
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);

  logic [WIDTH-1:0] term;
  logic             node_next;
  logic [CNT_W-1:0] cnt_next;

  nt_lane #(.DEPTH(DEPTH)) u_lane [WIDTH-1:0] (
    .clk   (I1470_clk),
    .rst_n (I1477_rst),
    .a     (a_in),
    .b     (b_in),
    .term  (term)
  );

  assign node_next = (MODE == 0) ? |term : &term;

  // Count advances on cycles where the registered node was active; it holds
  // at CNT_MAX instead of wrapping.
  always_comb begin
    cnt_next = count;
    if (en && node_out && (count != CNT_MAX)) cnt_next = count + CNT_W'(1);
  end

  always_ff @(posedge I1470_clk or negedge I1477_rst) begin
    if (!I1477_rst) begin
      node_out <= 1'b0;
      count    <= '0;
      fire     <= 1'b0;
    end else begin
      node_out <= node_next;
      if (clr) begin
        count <= '0;
        fire  <= 1'b0;
      end else begin
        count <= cnt_next;
        // Compare the value being written so fire rises on the same edge
        // that count reaches the threshold.
        if (cnt_next >= THR) fire <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_nt_node_trigger_monitor.sv
module tb_nt_node_trigger_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // u0: WIDTH=4 DEPTH=2 MODE=0 CNT_W=8 THRESH=16
  logic [3:0] a0 = '0, b0 = '0;
  logic       en0 = 1'b0, clr0 = 1'b0;
  logic       node0, fire0;
  logic [7:0] count0;
  // u1: WIDTH=4 DEPTH=1 MODE=1
  logic [3:0] a1 = '0, b1 = '0;
  logic       node1, fire1;
  logic [7:0] count1;
  // u2: WIDTH=4 DEPTH=2 MODE=0 CNT_W=4 THRESH=15
  logic [3:0] a2 = '0, b2 = '0;
  logic       en2 = 1'b0;
  logic       node2, fire2;
  logic [3:0] count2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  nt_node_trigger_monitor #(.WIDTH(4), .DEPTH(2), .MODE(0), .CNT_W(8), .THRESH(16)) u0 (
    .I1470_clk(clk), .I1477_rst(rst_n), .a_in(a0), .b_in(b0), .en(en0), .clr(clr0),
    .node_out(node0), .count(count0), .fire(fire0));

  nt_node_trigger_monitor #(.WIDTH(4), .DEPTH(1), .MODE(1), .CNT_W(8), .THRESH(16)) u1 (
    .I1470_clk(clk), .I1477_rst(rst_n), .a_in(a1), .b_in(b1), .en(1'b0), .clr(1'b0),
    .node_out(node1), .count(count1), .fire(fire1));

  nt_node_trigger_monitor #(.WIDTH(4), .DEPTH(2), .MODE(0), .CNT_W(4), .THRESH(15)) u2 (
    .I1470_clk(clk), .I1477_rst(rst_n), .a_in(a2), .b_in(b2), .en(en2), .clr(1'b0),
    .node_out(node2), .count(count2), .fire(fire2));

  task automatic test_reset;
    int exp_node;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({node0, count0, fire0, node1, fire1, node2, count2, fire2} !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: node0=%b count0=%0d fire0=%b node1=%b node2=%b count2=%0d fire2=%b, required all 0",
                 c, node0, count0, fire0, node1, node2, count2, fire2);
      end
    end
    rst_n = 1'b1;              // released between edges
    @(posedge clk); #1;        // edge 0
    a0 = 4'b0001; b0 = '0;
    @(posedge clk); #1;        // edge 1 captures the pulse
    a0 = '0;
    for (int e = 1; e <= 6; e++) begin
      if (e > 1) @(posedge clk);
      @(negedge clk);
      exp_node = (e == 3) ? 1 : 0;
      n_checks++;
      if (node0 !== exp_node[0]) begin
        n_fail++;
        $display("FAIL latency after edge %0d: node_out=%b required %b", e, node0, exp_node[0]);
      end
    end
    n_checks++;
    if (count0 !== 8'd0 || fire0 !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_no_count: count=%0d fire=%b required 0/0 with en=0", count0, fire0);
    end
  endtask

  task automatic test_mode_and;
    @(posedge clk); #1; a1 = 4'hF; b1 = 4'h0;
    @(posedge clk); #1; a1 = 4'hF; b1 = 4'h2;
    @(negedge clk);
    n_checks++;
    if (node1 !== 1'b0) begin
      n_fail++;
      $display("FAIL and_pre: node_out=%b required 0", node1);
    end
    @(posedge clk); #1; a1 = '0; b1 = '0;
    @(negedge clk);
    n_checks++;
    if (node1 !== 1'b1) begin
      n_fail++;
      $display("FAIL and_all_terms: node_out=%b required 1", node1);
    end
    @(negedge clk);
    n_checks++;
    if (node1 !== 1'b0) begin
      n_fail++;
      $display("FAIL and_one_blocked: node_out=%b required 0", node1);
    end
  endtask

  task automatic test_saturation;
    int lim;
    int exp_cnt;
    a2 = 4'b0100; en2 = 1'b1;
    lim = 0;
    do begin @(negedge clk); lim++; end while (node2 !== 1'b1 && lim < 20);
    n_checks++;
    if (node2 !== 1'b1 || count2 !== 4'd0) begin
      n_fail++;
      $display("FAIL sat_start: node_out=%b count=%0d required 1/0", node2, count2);
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_cnt = (k > 15) ? 15 : k;
      n_checks++;
      if (count2 !== exp_cnt[3:0] || fire2 !== (k >= 15)) begin
        n_fail++;
        $display("FAIL sat_step%0d: count=%0d fire=%b required %0d/%b", k, count2, fire2, exp_cnt, (k >= 15));
      end
    end
    a2 = '0; en2 = 1'b0;
  endtask

  task automatic test_threshold;
    int lim;
    a0 = 4'b0001; b0 = '0; en0 = 1'b1;
    lim = 0;
    do begin @(negedge clk); lim++; end while (node0 !== 1'b1 && lim < 20);
    n_checks++;
    if (node0 !== 1'b1 || count0 !== 8'd0) begin
      n_fail++;
      $display("FAIL thr_start: node_out=%b count=%0d required 1/0", node0, count0);
    end
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      n_checks++;
      if (count0 !== k[7:0] || fire0 !== (k >= 16)) begin
        n_fail++;
        $display("FAIL thr_step%0d: count=%0d fire=%b required %0d/%b", k, count0, fire0, k, (k >= 16));
      end
    end
    // Node still carries three active cycles in the pipe: count ends at 19.
    a0 = '0;
    repeat (5) @(negedge clk);
    n_checks++;
    if (node0 !== 1'b0 || fire0 !== 1'b1 || count0 !== 8'd19) begin
      n_fail++;
      $display("FAIL thr_sticky: node_out=%b fire=%b count=%0d required 0/1/19", node0, fire0, count0);
    end
    en0 = 1'b0;
    a0 = 4'b1000;
    repeat (5) @(negedge clk);
    n_checks++;
    if (node0 !== 1'b1 || count0 !== 8'd19 || fire0 !== 1'b1) begin
      n_fail++;
      $display("FAIL en_freeze: node_out=%b count=%0d fire=%b required 1/19/1", node0, count0, fire0);
    end
  endtask

  task automatic test_clr_priority;
    int lim;
    // node_out is already 1 from the frozen phase; re-enable and clear together.
    en0 = 1'b1; clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    n_checks++;
    if (count0 !== 8'd0 || fire0 !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_priority: count=%0d fire=%b required 0/0", count0, fire0);
    end
    @(negedge clk);
    n_checks++;
    if (count0 !== 8'd1 || fire0 !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_resume: count=%0d fire=%b required 1/0", count0, fire0);
    end
    lim = 0;
    while (count0 !== 8'd9 && lim < 30) begin @(negedge clk); lim++; end
    n_checks++;
    if (count0 !== 8'd9) begin
      n_fail++;
      $display("FAIL reach_9: count=%0d required 9 (timeout)", count0);
    end
  endtask

  task automatic test_async_reset;
    // Called on a negedge: assert reset between edges and look before any edge.
    rst_n = 1'b0; a0 = '0;
    #1;
    n_checks++;
    if (count0 !== 8'd0 || fire0 !== 1'b0 || node0 !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: count=%0d fire=%b node_out=%b required 0/0/0", count0, fire0, node0);
    end
    @(posedge clk); #1;
    n_checks++;
    if (count0 !== 8'd0 || node0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_held: count=%0d node_out=%b required 0/0", count0, node0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++;
      if (node0 !== 1'b0 || count0 !== 8'd0) begin
        n_fail++;
        $display("FAIL stale_pipe cyc%0d: node_out=%b count=%0d required 0/0", c, node0, count0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode_and();
    test_saturation();
    test_threshold();
    test_clr_priority();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
